temp_sensor_filter: RTL and testbench
=====================================

// Module: temp_sensor_filter
// PURPOSE
//  Upstream conditioning stage for the incubator controller. Accepts raw signed
//  8-bit temperature samples, rejects isolated spikes, and averages the last DEPTH
//  accepted samples. Drives the controller's `sensor` input with a stable
//  registered value.
//  Raises a fault flag when the raw sample stream goes silent.
// PARAMETERS
//  DEPTH          4     averaging window in samples; power of 2, range 2..16
//  MAX_STEP       8     max |raw - sensor| accepted without spike check (degrees)
//  SPIKE_PERSIST  3     consecutive out-of-step samples before the step is accepted as real
//  TIMEOUT        1000  clk cycles without raw_valid before sensor_fault asserts
// PORTS
//  clk            in   1  system clock, rising edge
//  reset          in   1  synchronous, active-high reset
//  raw_temp       in   8  signed raw sample, two's complement degrees
//  raw_valid      in   1  raw_temp qualifier, one-cycle strobe per sample
//  sensor         out  8  signed filtered temperature to incubator; registered
//  sensor_valid   out  1  level; 1 while window is full and no fault is present
//  sensor_update  out  1  one-cycle pulse in the same cycle `sensor` takes a new value
//  sensor_fault   out  1  level; sample stream timeout
// BEHAVIOUR
//  Reset: sensor=0, sensor_valid=0, sensor_update=0, sensor_fault=0, state=FILL,
//    fill count=0, wr_ptr=0, sum=0, spike_cnt=0, timeout counter=0.
//    Reset has priority over raw_valid in the same cycle.
//  Arithmetic:
//    - sum is signed, 8+log2(DEPTH) bits; it cannot overflow.
//    - average = sum >>> log2(DEPTH), arithmetic shift, i.e. floor toward -inf.
//    - step check uses a 9-bit signed diff = raw_temp - sensor, compared by |diff|.
//  Accept of sample s: buf[wr_ptr]<=s; sum<=sum-buf[wr_ptr]+s; wr_ptr wraps mod DEPTH.
//    Buffer entries are 0 after reset, so the running sum stays exact during FILL.
//  Latency: sensor and sensor_update change on the clk edge after the raw_valid
//    cycle of an accepted sample (1 cycle). Dropped samples: no change, no pulse.
//  FSM FILL:
//    - every raw_valid sample is accepted with no spike check;
//    - sensor and sensor_update are untouched until the DEPTH-th accept;
//    - on the DEPTH-th accept: sensor<=average of the new sum, sensor_update=1,
//      sensor_valid<=1, -> RUN.
//  FSM RUN, on raw_valid:
//    - if |diff| <= MAX_STEP: accept, spike_cnt<=0, update sensor and pulse.
//    - else if spike_cnt==SPIKE_PERSIST-1: accept, spike_cnt<=0, update and pulse.
//    - else: drop the sample, spike_cnt++.
//    - spike_cnt counts consecutive out-of-step samples only; any in-step sample
//      clears it.
//  Timeout:
//    - counter clears on every raw_valid and increments otherwise; saturates at TIMEOUT.
//    - when it reaches TIMEOUT: sensor_fault<=1, sensor_valid<=0, state<=FILL,
//      fill count/wr_ptr/sum/spike_cnt and buffer cleared; sensor holds its last value.
//  Fault recovery:
//    - the next raw_valid clears sensor_fault in the same edge as its accept;
//    - that sample is the first of a new FILL.
//  Simultaneous raw_valid with the timeout-reaching cycle: the sample wins, no fault.
//  Samples arriving on back-to-back cycles are all processed; there is no
//    backpressure.
// STRUCTURE
//  Shared package incubator_pkg:
//    - TEMP_W=8;
//    - signed temperature typedef temp_t;
//    - fsm enum {FILL, RUN}.
//    The incubator controller uses the same temp_t.
//  Sub-module sample_window:
//    - DEPTH-entry circular buffer plus running sum;
//    - ports: write strobe, data in, clear, evicted entry, sum out.
//    The top level holds the FSM, spike check, timeout counter and output registers.
// TESTING  (DEPTH=4, MAX_STEP=8, SPIKE_PERSIST=3, TIMEOUT=1000)
//  1. reset; raw 20,22,24,26 -> no pulse on the first three; after the 4th:
//     sensor=23, sensor_valid=1, exactly one update pulse.
//  2. from test 1, raw 60 once -> dropped, sensor=23, no pulse;
//     then 60,60 -> the 3rd 60 is accepted (replaces 20), sensor=(132>>>2)=33.
//  3. reset; raw -10,-11,-11,-11 -> sum=-43, sensor=-11 (floor), sensor_valid=1.
//  4. window full; no raw_valid for 1000 cycles -> sensor_fault=1, sensor_valid=0,
//     sensor held; next raw_valid clears fault, sensor_valid stays 0 until 4 samples.
//  5. reset asserted in the same cycle as raw_valid, and again mid-FILL after 2
//     samples -> all outputs 0, the following 4 samples are needed for sensor_valid.
//  6. RUN: raw 40,23,40,40 alternating from sensor=23 -> in-step 23 clears
//     spike_cnt, so no 40 is accepted until three consecutive 40s arrive.

Source files
------------

// File: rtl/incubator_pkg.sv
// Shared temperature types for the incubator datapath and its controller.
// Pure declarations: no latency, no flow control.
package incubator_pkg;

    localparam int TEMP_W = 8;

    typedef logic signed [TEMP_W-1:0] temp_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    // |a - b| computed one bit wider so the full -128..127 span cannot wrap.
    function automatic logic [TEMP_W:0] abs_step(input temp_t a, input temp_t b);
        logic signed [TEMP_W:0] diff;
        diff = {a[TEMP_W-1], a} - {b[TEMP_W-1], b};
        return diff[TEMP_W] ? (TEMP_W+1)'(-diff) : (TEMP_W+1)'(diff);
    endfunction

endpackage

// File: rtl/temp_sensor_filter_if.sv
// Raw sample strobe in, filtered temperature and status levels out.
// Wires only; the filter never stalls the sample source.
interface temp_sensor_filter_if;

    incubator_pkg::temp_t raw_temp;
    logic                 raw_valid;
    incubator_pkg::temp_t sensor;
    logic                 sensor_valid;
    logic                 sensor_update;
    logic                 sensor_fault;

    modport master (
        output raw_temp, raw_valid,
        input  sensor, sensor_valid, sensor_update, sensor_fault
    );

    modport slave (
        input  raw_temp, raw_valid,
        output sensor, sensor_valid, sensor_update, sensor_fault
    );

endinterface

// File: rtl/sample_window.sv
// DEPTH-entry circular sample buffer with an exact running sum of its entries.
// Write takes effect on the next edge; no backpressure, a write is always taken.
module sample_window
    import incubator_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SUM_W = TEMP_W + $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_i,
    input  temp_t                   din_i,
    input  logic                    clr_i,
    output temp_t                   evict_o,
    output logic signed [SUM_W-1:0] sum_o
);

    localparam int PTR_W = $clog2(DEPTH);

    temp_t                   win_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic signed [SUM_W-1:0] sum_q;
    logic signed [SUM_W-1:0] sum_d;

    assign evict_o = win_q[wr_ptr_q];
    assign sum_o   = sum_q;

    // Cleared entries are zero, so subtracting the evicted entry is exact while filling.
    assign sum_d = sum_q - SUM_W'(evict_o) + SUM_W'(din_i);

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            sum_q    <= '0;
        end else if (wr_i) begin
            win_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            sum_q           <= sum_d;
        end
    end

endmodule

// File: rtl/temp_sensor_filter.sv
// Spike-rejecting moving average of raw temperature samples with a stream-silence fault.
// Accepted sample updates sensor one cycle later; no backpressure, every raw_valid is consumed.
module temp_sensor_filter
    import incubator_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int MAX_STEP      = 8,
    parameter int SPIKE_PERSIST = 3,
    parameter int TIMEOUT       = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    temp_sensor_filter_if.slave  sif
);

    localparam int LOG2  = $clog2(DEPTH);
    localparam int SUM_W = TEMP_W + LOG2;
    localparam int CNT_W = LOG2 + 1;
    localparam int SP_W  = $clog2(SPIKE_PERSIST) + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [TEMP_W:0]  STEP_LIM  = (TEMP_W+1)'(MAX_STEP);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(DEPTH - 1);
    localparam logic [SP_W-1:0]  SP_LAST   = SP_W'(SPIKE_PERSIST - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT);

    fsm_t             state_q,     state_d;
    logic [CNT_W-1:0] fill_cnt_q,  fill_cnt_d;
    logic [SP_W-1:0]  spike_cnt_q, spike_cnt_d;
    logic [TO_W-1:0]  to_cnt_q,    to_cnt_d;
    temp_t            sensor_q,    sensor_d;
    logic             valid_q,     valid_d;
    logic             update_q,    update_d;
    logic             fault_q,     fault_d;

    logic                    win_wr;
    logic                    win_clr;
    temp_t                   win_evict;
    logic signed [SUM_W-1:0] win_sum;
    logic signed [SUM_W-1:0] sum_new;
    temp_t                   avg;
    logic                    in_step;

    sample_window #(
        .DEPTH (DEPTH),
        .SUM_W (SUM_W)
    ) u_window (
        .clk     (clk),
        .reset   (reset),
        .wr_i    (win_wr),
        .din_i   (sif.raw_temp),
        .clr_i   (win_clr),
        .evict_o (win_evict),
        .sum_o   (win_sum)
    );

    // Average of the window as it will be after this sample is written.
    assign sum_new = win_sum - SUM_W'(win_evict) + SUM_W'(sif.raw_temp);
    assign avg     = temp_t'(sum_new >>> LOG2);
    assign in_step = abs_step(sif.raw_temp, sensor_q) <= STEP_LIM;

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        spike_cnt_d = spike_cnt_q;
        to_cnt_d    = to_cnt_q;
        sensor_d    = sensor_q;
        valid_d     = valid_q;
        update_d    = 1'b0;
        fault_d     = fault_q;
        win_wr      = 1'b0;
        win_clr     = 1'b0;

        if (sif.raw_valid) begin
            to_cnt_d = '0;
            fault_d  = 1'b0;
            case (state_q)
                FILL: begin
                    win_wr     = 1'b1;
                    fill_cnt_d = fill_cnt_q + CNT_W'(1);
                    if (fill_cnt_q == FILL_LAST) begin
                        sensor_d = avg;
                        update_d = 1'b1;
                        valid_d  = 1'b1;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    if (in_step || spike_cnt_q == SP_LAST) begin
                        win_wr      = 1'b1;
                        spike_cnt_d = '0;
                        sensor_d    = avg;
                        update_d    = 1'b1;
                    end else begin
                        spike_cnt_d = spike_cnt_q + SP_W'(1);
                    end
                end
                default: state_d = FILL;
            endcase
        end else if (to_cnt_q == TO_LAST) begin
            // Stream went silent: drop the stale window, hold the last sensor value.
            to_cnt_d    = TO_MAX;
            fault_d     = 1'b1;
            valid_d     = 1'b0;
            state_d     = FILL;
            fill_cnt_d  = '0;
            spike_cnt_d = '0;
            win_clr     = 1'b1;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            spike_cnt_q <= '0;
            to_cnt_q    <= '0;
            sensor_q    <= '0;
            valid_q     <= 1'b0;
            update_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            spike_cnt_q <= spike_cnt_d;
            to_cnt_q    <= to_cnt_d;
            sensor_q    <= sensor_d;
            valid_q     <= valid_d;
            update_q    <= update_d;
            fault_q     <= fault_d;
        end
    end

    assign sif.sensor        = sensor_q;
    assign sif.sensor_valid  = valid_q;
    assign sif.sensor_update = update_q;
    assign sif.sensor_fault  = fault_q;

endmodule

// File: tb/tb_temp_sensor_filter.sv
// Directed bench for temp_sensor_filter: a reference model pushes expected outputs per cycle,
// which are popped and compared one cycle after each drive.
module tb_temp_sensor_filter;
    import incubator_pkg::*;

    logic clk;
    logic reset;

    temp_sensor_filter_if sif ();

    temp_sensor_filter #(
        .DEPTH         (4),
        .MAX_STEP      (8),
        .SPIKE_PERSIST (3),
        .TIMEOUT       (1000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sensor;
        bit valid;
        bit upd;
        bit fault;
    } exp_t;

    exp_t sbq[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model state
    int m_win[4];
    int m_ptr, m_fill, m_spike, m_to, m_sum, m_sensor;
    bit m_run, m_valid, m_fault, m_upd;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void m_clear_window();
        for (int i = 0; i < 4; i++) m_win[i] = 0;
        m_ptr = 0; m_fill = 0; m_spike = 0; m_sum = 0; m_run = 0;
    endfunction

    function automatic void m_push();
        exp_t e;
        e.sensor = m_sensor; e.valid = m_valid; e.upd = m_upd; e.fault = m_fault;
        sbq.push_back(e);
    endfunction

    function automatic void m_reset();
        m_clear_window();
        m_to = 0; m_sensor = 0; m_valid = 0; m_fault = 0; m_upd = 0;
        m_push();
    endfunction

    function automatic void m_step(input bit v, input int t);
        bit accept;
        int mag;
        m_upd  = 0;
        accept = 0;
        if (v) begin
            m_to = 0;
            m_fault = 0;
            mag = (t > m_sensor) ? t - m_sensor : m_sensor - t;
            if (!m_run) accept = 1;
            else if (mag <= 8 || m_spike == 2) begin accept = 1; m_spike = 0; end
            else m_spike++;
            if (accept) begin
                m_sum = m_sum - m_win[m_ptr] + t;
                m_win[m_ptr] = t;
                m_ptr = (m_ptr + 1) % 4;
                if (!m_run) begin
                    m_fill++;
                    if (m_fill == 4) begin
                        m_run = 1; m_valid = 1; m_upd = 1; m_sensor = m_sum >>> 2;
                    end
                end else begin
                    m_upd = 1; m_sensor = m_sum >>> 2;
                end
            end
        end else if (m_to == 999) begin
            m_to = 1000; m_fault = 1; m_valid = 0;
            m_clear_window();
        end else if (m_to < 1000) begin
            m_to++;
        end
        m_push();
    endfunction

    task automatic compare_out(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
        end else begin
            e = sbq.pop_front();
            chk({tag, ".sensor"}, int'(sif.sensor), e.sensor);
            chk({tag, ".valid"},  int'(sif.sensor_valid), int'(e.valid));
            chk({tag, ".update"}, int'(sif.sensor_update), int'(e.upd));
            chk({tag, ".fault"},  int'(sif.sensor_fault), int'(e.fault));
        end
    endtask

    task automatic do_reset(input bit v, input int t, input string tag);
        @(negedge clk);
        reset = 1'b1;
        sif.raw_valid = v;
        sif.raw_temp  = temp_t'(t);
        m_reset();
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic step(input bit v, input int t, input string tag);
        @(negedge clk);
        reset = 1'b0;
        sif.raw_valid = v;
        sif.raw_temp  = temp_t'(t);
        m_step(v, t);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    initial begin
        reset = 1'b1;
        sif.raw_valid = 1'b0;
        sif.raw_temp  = '0;

        // 1. Fill with 20,22,24,26 -> 23
        do_reset(0, 0, "t1_rst");
        step(1, 20, "t1_s0");
        step(1, 22, "t1_s1");
        step(1, 24, "t1_s2");
        step(1, 26, "t1_s3");
        chk("t1_sensor23", int'(sif.sensor), 23);
        step(0, 0, "t1_idle");

        // 2. Spike of 60 needs three consecutive samples
        step(1, 60, "t2_d0");
        step(1, 60, "t2_d1");
        step(1, 60, "t2_acc");
        chk("t2_sensor33", int'(sif.sensor), 33);
        chk("t2_pulse", int'(sif.sensor_update), 1);

        // 3. Negative values floor toward -inf
        do_reset(0, 0, "t3_rst");
        step(1, -10, "t3_s0");
        step(1, -11, "t3_s1");
        step(1, -11, "t3_s2");
        step(1, -11, "t3_s3");
        chk("t3_sensor_m11", int'(sif.sensor), -11);
        chk("t3_valid", int'(sif.sensor_valid), 1);

        // 4a. Sample on the timeout-reaching cycle wins
        for (int i = 0; i < 999; i++) step(0, 0, "t4a_idle");
        step(1, -11, "t4a_save");
        chk("t4a_nofault", int'(sif.sensor_fault), 0);

        // 4b. Full silence -> fault, sensor held; recovery refills
        for (int i = 0; i < 999; i++) step(0, 0, "t4b_idle");
        chk("t4b_prefault", int'(sif.sensor_fault), 0);
        step(0, 0, "t4b_timeout");
        chk("t4b_fault", int'(sif.sensor_fault), 1);
        chk("t4b_held", int'(sif.sensor), -11);
        for (int i = 0; i < 5; i++) step(0, 0, "t4b_sat");
        step(1, 30, "t4b_rec0");
        chk("t4b_fault_clr", int'(sif.sensor_fault), 0);
        chk("t4b_novalid", int'(sif.sensor_valid), 0);
        step(1, 30, "t4b_rec1");
        step(1, 30, "t4b_rec2");
        step(1, 30, "t4b_rec3");
        chk("t4b_revalid", int'(sif.sensor_valid), 1);

        // 5. Reset beats raw_valid; reset mid-FILL restarts the fill count
        do_reset(1, 50, "t5_rst_v");
        chk("t5_sensor0", int'(sif.sensor), 0);
        step(1, 5, "t5_s0");
        step(1, 6, "t5_s1");
        do_reset(0, 0, "t5_rst_mid");
        step(1, 7, "t5_a0");
        step(1, 7, "t5_a1");
        step(1, 7, "t5_a2");
        chk("t5_notyet", int'(sif.sensor_valid), 0);
        step(1, 9, "t5_a3");
        chk("t5_sensor7", int'(sif.sensor), 7);

        // 6. In-step sample between spikes resets the persistence count
        do_reset(0, 0, "t6_rst");
        for (int i = 0; i < 4; i++) step(1, 23, "t6_fill");
        step(1, 40, "t6_d0");
        step(1, 23, "t6_in");
        step(1, 40, "t6_d1");
        step(1, 40, "t6_d2");
        chk("t6_still23", int'(sif.sensor), 23);
        step(1, 40, "t6_acc");
        chk("t6_sensor27", int'(sif.sensor), 27);
        step(1, -5, "t6_d3");
        step(1, 60, "t6_d4");
        step(1, 127, "t6_acc2");

        sif.raw_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
